// File: rtl/speed_trap_gate.sv
// Two-sensor speed trap with E-pass barrier control.
// Define SPEED_TRAP_OVERSPEED_EN to flag overspeed and reject speeding vehicles.
module speed_trap_gate #(
    parameter int SYS_FREQ        = 50000000,
    parameter int WIDTH_MS        = 12,
    parameter int WIDTH_SPEED     = 14,
    parameter int DIST_MM         = 4000,
    parameter int SPEED_LIMIT     = 600,
    parameter int PASS_TIMEOUT_MS = 2000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sensor1,
    input  logic                   sensor2,
    input  logic                   sensor3,
    input  logic [1:0]             valid_Epass,
    input  logic                   enable,
    output logic [WIDTH_SPEED-1:0] speed,
    output logic                   speed_valid,
    output logic                   overspeed,
    output logic                   barrier,
    output logic                   busy,
    output logic                   error
);

    localparam int PRE      = SYS_FREQ / 1000;
    localparam int PW       = (PRE > 1) ? $clog2(PRE) : 1;
    localparam int DIVIDEND = DIST_MM * 36;
    localparam int QW       = $clog2(DIVIDEND + 1);
    localparam int SW       = $clog2(QW + 1);
    localparam int CW       = (QW > WIDTH_SPEED) ? QW : WIDTH_SPEED;

    localparam logic [WIDTH_MS-1:0]    MS_MAX   = '1;
    localparam logic [WIDTH_MS-1:0]    PASS_TO  = WIDTH_MS'(PASS_TIMEOUT_MS);
    localparam logic [WIDTH_SPEED-1:0] SPD_MAX  = '1;
    localparam logic [PW-1:0]          PRE_LAST = PW'(PRE - 1);
    localparam logic [QW-1:0]          DVD      = QW'(DIVIDEND);
    localparam logic [SW-1:0]          LAST_STEP = SW'(QW);

    typedef enum logic [2:0] {
        IDLE, TIMING, DIVIDE, WAIT_PASS, OPEN, REJECT
    } state_t;

    state_t state;

    logic [2:0] s_meta, s_sync, s_prev, warm;
    logic [2:0] s_rise, s_fall;

    logic [PW-1:0]          presc;
    logic [WIDTH_MS-1:0]    ms_count, ms_inc, divisor, rem;
    logic [WIDTH_MS:0]      rem_sh, rem_nx;
    logic [QW-1:0]          quo;
    logic [SW-1:0]          step;
    logic                   ms_tick, fits, sat;
    logic [WIDTH_SPEED-1:0] spd_res;
    logic                   ovs_block;

    // Edges are masked until the pipeline has refilled after reset, so a
    // sensor held high through reset does not look like a fresh arrival.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_meta <= '0;
            s_sync <= '0;
            s_prev <= '0;
            warm   <= '0;
        end else begin
            s_meta <= {sensor3, sensor2, sensor1};
            s_sync <= s_meta;
            s_prev <= s_sync;
            warm   <= {warm[1:0], 1'b1};
        end
    end

    assign s_rise = s_sync & ~s_prev & {3{warm[2]}};
    assign s_fall = ~s_sync & s_prev & {3{warm[2]}};

    assign ms_tick = (presc == PRE_LAST);
    assign ms_inc  = (ms_count == MS_MAX) ? MS_MAX : ms_count + 1'b1;

    assign rem_sh  = {rem, quo[QW-1]};
    assign fits    = (rem_sh >= {1'b0, divisor});
    assign rem_nx  = fits ? rem_sh - {1'b0, divisor} : rem_sh;
    assign sat     = (divisor == '0) || (CW'(quo) > CW'(SPD_MAX));
    assign spd_res = sat ? SPD_MAX : WIDTH_SPEED'(quo);

    assign busy = (state != IDLE);

`ifdef SPEED_TRAP_OVERSPEED_EN
    logic ovs_q;
    assign overspeed = ovs_q;
    assign ovs_block = ovs_q;
`else
    assign overspeed = 1'b0;
    assign ovs_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            presc       <= '0;
            ms_count    <= '0;
            divisor     <= '0;
            rem         <= '0;
            quo         <= '0;
            step        <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
            barrier     <= 1'b0;
            error       <= 1'b0;
`ifdef SPEED_TRAP_OVERSPEED_EN
            ovs_q       <= 1'b0;
`endif
        end else begin
            speed_valid <= 1'b0;
            error       <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                barrier <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        barrier <= 1'b0;
                        if (s_rise[0]) begin
                            presc    <= '0;
                            ms_count <= '0;
                            // Both sensors in one cycle: zero interval, saturates.
                            if (s_rise[1]) begin
                                divisor <= '0;
                                quo     <= DVD;
                                rem     <= '0;
                                step    <= '0;
                                state   <= DIVIDE;
                            end else begin
                                state   <= TIMING;
                            end
                        end
                    end
                    TIMING: begin
                        if (s_rise[1]) begin
                            divisor <= ms_tick ? ms_inc : ms_count;
                            quo     <= DVD;
                            rem     <= '0;
                            step    <= '0;
                            state   <= DIVIDE;
                        end else if (ms_count == MS_MAX) begin
                            error   <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            presc <= ms_tick ? '0 : presc + 1'b1;
                            if (ms_tick) ms_count <= ms_inc;
                        end
                    end
                    DIVIDE: begin
                        if (step == LAST_STEP) begin
                            speed       <= spd_res;
                            speed_valid <= 1'b1;
`ifdef SPEED_TRAP_OVERSPEED_EN
                            ovs_q       <= (int'(spd_res) > SPEED_LIMIT);
`endif
                            presc       <= '0;
                            ms_count    <= '0;
                            state       <= WAIT_PASS;
                        end else begin
                            rem  <= WIDTH_MS'(rem_nx);
                            quo  <= {quo[QW-2:0], fits};
                            step <= step + 1'b1;
                        end
                    end
                    WAIT_PASS: begin
                        if (valid_Epass == 2'b01) begin
                            if (ovs_block) begin
                                error <= 1'b1;
                                state <= REJECT;
                            end else begin
                                state <= OPEN;
                            end
                        end else if (valid_Epass[1]) begin
                            error <= 1'b1;
                            state <= REJECT;
                        end else if (ms_count == PASS_TO) begin
                            error <= 1'b1;
                            state <= REJECT;
                        end else begin
                            presc <= ms_tick ? '0 : presc + 1'b1;
                            if (ms_tick) ms_count <= ms_inc;
                        end
                    end
                    OPEN: begin
                        if (s_fall[2]) begin
                            barrier <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            barrier <= 1'b1;
                        end
                    end
                    REJECT: begin
                        barrier <= 1'b0;
                        if (!s_sync[1]) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_speed_trap_gate.sv
// Directed-vector bench for speed_trap_gate at SYS_FREQ=1000 (1 cycle = 1 ms).
module tb_speed_trap_gate;

`ifdef SPEED_TRAP_OVERSPEED_EN
    localparam int OVS_EN = 1;
`else
    localparam int OVS_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sensor1 = 1'b0, sensor2 = 1'b0, sensor3 = 1'b0;
    logic [1:0]  valid_Epass = 2'b00;
    logic        enable = 1'b1;
    logic [13:0] speed;
    logic        speed_valid, overspeed, barrier, busy, error;

    int n_vec = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int sv_cnt = 0;

    speed_trap_gate #(
        .SYS_FREQ(1000), .WIDTH_MS(12), .WIDTH_SPEED(14),
        .DIST_MM(4000), .SPEED_LIMIT(600), .PASS_TIMEOUT_MS(2000)
    ) dut (
        .clk(clk), .reset(reset),
        .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3),
        .valid_Epass(valid_Epass), .enable(enable),
        .speed(speed), .speed_valid(speed_valid), .overspeed(overspeed),
        .barrier(barrier), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (error) err_cnt++;
            if (speed_valid) sv_cnt++;
        end
    endtask

    task automatic wait_sv();
        for (int k = 0; k < 60 && sv_cnt == 0; k++) tick(1);
        check("sv_seen", sv_cnt, 1);
    endtask

    task automatic cleanup(input string tag);
        sensor1 = 1'b0;
        sensor2 = 1'b0;
        sensor3 = 1'b1;
        tick(6);
        sensor3 = 1'b0;
        tick(8);
        check(tag, busy, 0);
    endtask

    initial begin
        tick(3);
        check("rst_speed", speed, 0);
        check("rst_sv", speed_valid, 0);
        check("rst_ovs", overspeed, 0);
        check("rst_bar", barrier, 0);
        check("rst_busy", busy, 0);
        check("rst_err", error, 0);
        reset = 1'b0;
        tick(6);

        // 640 ms transit, E-pass presented early then properly
        err_cnt = 0; sv_cnt = 0;
        sensor1 = 1'b1;
        tick(5);
        valid_Epass = 2'b01;
        tick(5);
        check("a_busy", busy, 1);
        check("a_bar_tim", barrier, 0);
        valid_Epass = 2'b00;
        tick(630);
        sensor2 = 1'b1;
        wait_sv();
        check("a_speed", speed, 225);
        tick(2);
        check("a_sv_once", sv_cnt, 1);
        check("a_ovs", overspeed, 0);
        valid_Epass = 2'b01;
        tick(1);
        valid_Epass = 2'b00;
        tick(5);
        check("a_bar_open", barrier, 1);
        check("a_err", err_cnt, 0);
        sensor1 = 1'b0;
        sensor2 = 1'b0;
        sensor3 = 1'b1;
        tick(6);
        check("a_bar_held", barrier, 1);
        sensor3 = 1'b0;
        tick(8);
        check("a_bar_closed", barrier, 0);
        check("a_idle", busy, 0);

        // 100 ms transit: 144 km/h
        err_cnt = 0; sv_cnt = 0;
        sensor1 = 1'b1;
        tick(100);
        sensor2 = 1'b1;
        wait_sv();
        check("b_speed", speed, 1440);
        check("b_ovs", overspeed, OVS_EN);
        valid_Epass = 2'b01;
        tick(1);
        valid_Epass = 2'b00;
        tick(5);
        check("b_bar", barrier, OVS_EN ? 0 : 1);
        check("b_err", err_cnt, OVS_EN);
        cleanup("b_idle");

        // simultaneous rise saturates, then invalid E-pass
        err_cnt = 0; sv_cnt = 0;
        sensor1 = 1'b1;
        sensor2 = 1'b1;
        wait_sv();
        check("c_speed", speed, 16383);
        check("c_ovs", overspeed, OVS_EN);
        check("c_err0", err_cnt, 0);
        valid_Epass = 2'b11;
        tick(1);
        valid_Epass = 2'b00;
        tick(5);
        check("c_err", err_cnt, 1);
        check("c_bar", barrier, 0);
        check("c_reject", busy, 1);
        cleanup("c_idle");

        // no sensor2: interval counter timeout
        err_cnt = 0; sv_cnt = 0;
        sensor1 = 1'b1;
        tick(4090);
        check("d_busy", busy, 1);
        check("d_err0", err_cnt, 0);
        tick(20);
        check("d_err", err_cnt, 1);
        check("d_idle", busy, 0);
        check("d_speed", speed, 16383);
        check("d_sv", sv_cnt, 0);
        sensor1 = 1'b0;
        tick(5);

        // no E-pass: pass timeout
        err_cnt = 0; sv_cnt = 0;
        sensor1 = 1'b1;
        tick(640);
        sensor2 = 1'b1;
        wait_sv();
        check("e_speed", speed, 225);
        tick(1990);
        check("e_busy", busy, 1);
        check("e_err0", err_cnt, 0);
        tick(20);
        check("e_err", err_cnt, 1);
        check("e_bar", barrier, 0);
        cleanup("e_idle");

        // reset while barrier open
        err_cnt = 0; sv_cnt = 0;
        sensor1 = 1'b1;
        tick(640);
        sensor2 = 1'b1;
        wait_sv();
        valid_Epass = 2'b01;
        tick(1);
        valid_Epass = 2'b00;
        tick(3);
        check("f_bar_open", barrier, 1);
        reset = 1'b1;
        tick(1);
        check("f_bar", barrier, 0);
        check("f_busy", busy, 0);
        check("f_speed", speed, 0);
        reset = 1'b0;
        sensor1 = 1'b0;
        sensor2 = 1'b0;
        tick(6);

        // lane disabled mid-measurement
        err_cnt = 0;
        sensor1 = 1'b1;
        tick(20);
        check("g_busy", busy, 1);
        enable = 1'b0;
        tick(1);
        check("g_idle", busy, 0);
        tick(3);
        check("g_err", err_cnt, 0);
        enable = 1'b1;
        sensor1 = 1'b0;
        tick(5);
        check("g_still_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
